// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, MIPS opcode/funct values,
// the issued-op record and the skid-buffer occupancy states.
package alu_pkg;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        wr_en;
    } issue_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fill_t;

    // Harmless op issued in place of anything the decoder does not recognise.
    function automatic issue_t nop_issue(input logic [4:0] nop_dst);
        issue_t n;
        n.aluc  = ALU_ADDU;
        n.a     = 32'd0;
        n.b     = 32'd0;
        n.dst   = nop_dst;
        n.wr_en = 1'b0;
        return n;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS decode: instruction plus register reads -> ALU op record and a
// legal flag; the record is only meaningful when legal is high.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter logic [4:0] NOP_AREG = 5'd0
) (
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output issue_t      issue,
    output logic        legal
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm_s;
    logic [31:0] imm_z;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'h0000, instr[15:0]};

    // Defaults describe the common I-type shape (a=rs, dst=rt, writes back); each op overrides what differs.
    always_comb begin
        issue.aluc  = ALU_ADDU;
        issue.a     = rs_data;
        issue.b     = imm_s;
        issue.dst   = rt;
        issue.wr_en = 1'b1;
        legal       = 1'b1;
        case (op)
            OP_RTYPE: begin
                issue.b   = rt_data;
                issue.dst = rd;
                case (funct)
                    FN_ADD:  issue.aluc = ALU_ADD;
                    FN_ADDU: issue.aluc = ALU_ADDU;
                    FN_SUB:  issue.aluc = ALU_SUB;
                    FN_SUBU: issue.aluc = ALU_SUBU;
                    FN_AND:  issue.aluc = ALU_AND;
                    FN_OR:   issue.aluc = ALU_OR;
                    FN_XOR:  issue.aluc = ALU_XOR;
                    FN_NOR:  issue.aluc = ALU_NOR;
                    FN_SLT:  issue.aluc = ALU_SLT;
                    FN_SLTU: issue.aluc = ALU_SLTU;
                    FN_SLL:  begin issue.aluc = ALU_SLL; issue.a = {27'd0, shamt}; end
                    FN_SRL:  begin issue.aluc = ALU_SRL; issue.a = {27'd0, shamt}; end
                    FN_SRA:  begin issue.aluc = ALU_SRA; issue.a = {27'd0, shamt}; end
                    FN_SLLV: begin issue.aluc = ALU_SLL; issue.a = {27'd0, rs_data[4:0]}; end
                    FN_SRLV: begin issue.aluc = ALU_SRL; issue.a = {27'd0, rs_data[4:0]}; end
                    FN_SRAV: begin issue.aluc = ALU_SRA; issue.a = {27'd0, rs_data[4:0]}; end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI:  issue.aluc = ALU_ADD;
            OP_ADDIU: issue.aluc = ALU_ADDU;
            OP_SLTI:  issue.aluc = ALU_SLT;
            OP_SLTIU: issue.aluc = ALU_SLTU;
            OP_ANDI:  begin issue.aluc = ALU_AND; issue.b = imm_z; end
            OP_ORI:   begin issue.aluc = ALU_OR;  issue.b = imm_z; end
            OP_XORI:  begin issue.aluc = ALU_XOR; issue.b = imm_z; end
            OP_LUI:   begin issue.aluc = ALU_LUI; issue.a = 32'd0; issue.b = imm_z; end
            OP_LW:    issue.aluc = ALU_ADDU;
            OP_SW:    begin issue.dst = NOP_AREG; issue.wr_en = 1'b0; end
            OP_BEQ, OP_BNE: begin
                issue.aluc  = ALU_SUBU;
                issue.b     = rt_data;
                issue.dst   = NOP_AREG;
                issue.wr_en = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // r0 is hardwired zero, so a write to it is never performed.
        if (issue.dst == 5'd0) begin
            issue.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// Registered issue stage with a 2-entry skid FIFO between decode and EX.
// Optional ILLEGAL_TRAP_EN: drop unrecognised ops and pulse 'illegal' instead of issuing a NOP.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter logic [4:0] NOP_AREG = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  aluc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  dst,
    output logic        wr_en,
    output logic        illegal
);

    fill_t  state;
    fill_t  state_n;
    issue_t ent0;
    issue_t ent1;
    issue_t dec_issue;
    issue_t enq_issue;
    logic   dec_legal;
    logic   accept;
    logic   consume;
    logic   push;
    logic   in_ready_q;

    alu_op_decode #(
        .NOP_AREG(NOP_AREG)
    ) u_decode (
        .instr  (instr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .issue  (dec_issue),
        .legal  (dec_legal)
    );

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid && out_ready;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    assign push      = accept && dec_legal;
    assign enq_issue = dec_issue;
    assign illegal   = illegal_q;

    // A trapped op is swallowed; a flush in the same cycle also cancels its pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !dec_legal && !flush;
        end
    end
`else
    assign push      = accept;
    assign enq_issue = dec_legal ? dec_issue : nop_issue(NOP_AREG);
    assign illegal   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case ({push, consume})
                2'b10:   state_n = (state == EMPTY) ? ONE : TWO;
                2'b01:   state_n = (state == TWO) ? ONE : EMPTY;
                default: state_n = state;
            endcase
        end
    end

    // ent0 is always the head; a simultaneous push and pop slides ent1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
        end else if (!flush) begin
            case ({push, consume})
                2'b10: begin
                    if (state == EMPTY) begin
                        ent0 <= enq_issue;
                    end else begin
                        ent1 <= enq_issue;
                    end
                end
                2'b01: ent0 <= ent1;
                2'b11: begin
                    if (state == ONE) begin
                        ent0 <= enq_issue;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= enq_issue;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (2'(state_n) != 2'(DEPTH));
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign {aluc, alu_a, alu_b, dst, wr_en} = out_valid ? ent0 : '0;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: a reference decode model feeds an expectation queue,
// an independent monitor pops and compares on every output handshake.
module tb_alu_op_issue;

    localparam logic [4:0] NOP_AREG = 5'd0;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  aluc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  dst;
    logic        wr_en;
    logic        illegal;

    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 1;
    exp_t exp_q[$];

    logic [5:0] rfn_tab [0:15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] iop_tab [0:11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h23, 6'h2B, 6'h04, 6'h05};

    alu_op_issue #(
        .DEPTH(2),
        .NOP_AREG(NOP_AREG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .aluc     (aluc),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .dst      (dst),
        .wr_en    (wr_en),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // EX-side acceptance pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference decode written from the instruction-set rules, mnemonic by mnemonic.
    function automatic exp_t refIssue(input logic [31:0] ins, input logic [31:0] rsv,
                                      input logic [31:0] rtv, output bit ok);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] simm;
        logic [31:0] zimm;
        op   = ins[31:26];
        fn   = ins[5:0];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        ok   = 1'b1;
        e    = '{aluc: 4'h0, a: 32'h0, b: 32'h0, dst: NOP_AREG, wr: 1'b0};
        if (op == 6'h00) begin
            e.a   = rsv;
            e.b   = rtv;
            e.dst = ins[15:11];
            e.wr  = 1'b1;
            case (fn)
                6'h20: e.aluc = 4'h2;
                6'h21: e.aluc = 4'h0;
                6'h22: e.aluc = 4'h3;
                6'h23: e.aluc = 4'h1;
                6'h24: e.aluc = 4'h4;
                6'h25: e.aluc = 4'h5;
                6'h26: e.aluc = 4'h6;
                6'h27: e.aluc = 4'h7;
                6'h2A: e.aluc = 4'hB;
                6'h2B: e.aluc = 4'hA;
                6'h00: begin e.aluc = 4'hE; e.a = 32'(ins[10:6]); end
                6'h02: begin e.aluc = 4'hD; e.a = 32'(ins[10:6]); end
                6'h03: begin e.aluc = 4'hC; e.a = 32'(ins[10:6]); end
                6'h04: begin e.aluc = 4'hE; e.a = rsv & 32'd31; end
                6'h06: begin e.aluc = 4'hD; e.a = rsv & 32'd31; end
                6'h07: begin e.aluc = 4'hC; e.a = rsv & 32'd31; end
                default: ok = 1'b0;
            endcase
        end else begin
            e.a   = rsv;
            e.dst = ins[20:16];
            e.wr  = 1'b1;
            case (op)
                6'h08: begin e.aluc = 4'h2; e.b = simm; end
                6'h09: begin e.aluc = 4'h0; e.b = simm; end
                6'h0A: begin e.aluc = 4'hB; e.b = simm; end
                6'h0B: begin e.aluc = 4'hA; e.b = simm; end
                6'h0C: begin e.aluc = 4'h4; e.b = zimm; end
                6'h0D: begin e.aluc = 4'h5; e.b = zimm; end
                6'h0E: begin e.aluc = 4'h6; e.b = zimm; end
                6'h0F: begin e.aluc = 4'h8; e.a = 32'h0; e.b = zimm; end
                6'h23: begin e.aluc = 4'h0; e.b = simm; end
                6'h2B: begin e.aluc = 4'h0; e.b = simm; e.dst = NOP_AREG; e.wr = 1'b0; end
                6'h04, 6'h05: begin
                    e.aluc = 4'h1; e.b = rtv; e.dst = NOP_AREG; e.wr = 1'b0;
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) e = '{aluc: 4'h0, a: 32'h0, b: 32'h0, dst: NOP_AREG, wr: 1'b0};
        if (e.dst == 5'd0) e.wr = 1'b0;
        return e;
    endfunction

    function automatic exp_t dutOut();
        return {aluc, alu_a, alu_b, dst, wr_en};
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one op and hold it until the DUT takes it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] r_s, input logic [31:0] r_t);
        int   w = 0;
        bit   ok;
        exp_t e;
        instr    = i;
        rs_data  = r_s;
        rt_data  = r_t;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 80'(in_ready), 80'd1);
        end else begin
            e = refIssue(i, r_s, r_t, ok);
`ifdef ILLEGAL_TRAP_EN
            if (ok) exp_q.push_back(e);
`else
            exp_q.push_back(e);
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 80'(exp_q.size() == 0 && !out_valid), 80'd1);
    endtask

    function automatic logic [31:0] genInstr();
        int k;
        logic [31:0] r;
        r = $urandom;
        k = $urandom_range(0, 99);
`ifdef ILLEGAL_TRAP_EN
        if (k >= 95) k = 60;
`endif
        if (k < 50) begin
            r[31:26] = 6'h00;
            r[5:0]   = rfn_tab[$urandom_range(0, 15)];
        end else if (k < 95) begin
            r[31:26] = iop_tab[$urandom_range(0, 11)];
        end else begin
            r[31:26] = 6'h3F;
        end
        return r;
    endfunction

    // Monitor: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_issue", 80'(dutOut()), 80'd0);
            end else begin
                checkOutput("issue", 80'(dutOut()), 80'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e1;
        bit   ok;

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 80'(out_valid), 80'd0);
        checkOutput("rst_in_ready", 80'(in_ready), 80'd1);
        checkOutput("rst_aluc", 80'(aluc), 80'd0);
        checkOutput("rst_alu_a", 80'(alu_a), 80'd0);
        checkOutput("rst_alu_b", 80'(alu_b), 80'd0);
        checkOutput("rst_dst", 80'(dst), 80'd0);
        checkOutput("rst_wr_en", 80'(wr_en), 80'd0);
        checkOutput("rst_illegal", 80'(illegal), 80'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed decode cases, with the one-cycle latency checked on the first.
        rdy_mode = 1;
        @(negedge clk);
        applyStimulus(32'h00221820, 32'd5, 32'd7);
        checkOutput("latency_out_valid", 80'(out_valid), 80'd1);
        checkOutput("add_fields", 80'(dutOut()),
                    80'(exp_t'{aluc: 4'h2, a: 32'd5, b: 32'd7, dst: 5'd3, wr: 1'b1}));
        applyStimulus(32'h000520C3, 32'h1234_5678, 32'h8000_0000);
        applyStimulus(32'h2001FFFF, 32'd0, 32'd0);
        applyStimulus(32'h3001FFFF, 32'd0, 32'd0);
        applyStimulus(32'h00220021, 32'd1, 32'd2);
        applyStimulus(32'h10220005, 32'd9, 32'd4);
        applyStimulus(32'h8C450010, 32'h100, 32'd0);
        applyStimulus(32'hAC45FFF0, 32'h100, 32'd0);
        applyStimulus(32'h3C07ABCD, 32'hFFFF_FFFF, 32'd0);
        drain();

        // Stall: two ops fill the buffer, the third waits, head stays put.
        rdy_mode = 0;
        applyStimulus(32'h00221820, 32'd11, 32'd22);
        applyStimulus(32'h000520C3, 32'd0, 32'h8000_0000);
        checkOutput("full_in_ready", 80'(in_ready), 80'd0);
        e1 = refIssue(32'h00221820, 32'd11, 32'd22, ok);
        instr    = 32'h3001FFFF;
        rs_data  = 32'd3;
        rt_data  = 32'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 80'(in_ready), 80'd0);
            checkOutput("stall_hold", 80'(dutOut()), 80'(e1));
        end
        rdy_mode = 1;
        applyStimulus(32'h3001FFFF, 32'd3, 32'd0);
        drain();

        // Flush with a full buffer and a pending input: nothing may come out afterwards.
        rdy_mode = 0;
        applyStimulus(32'h00430820, 32'd1, 32'd1);
        applyStimulus(32'h00430822, 32'd2, 32'd2);
        instr    = 32'h00430824;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("flush2_out_valid", 80'(out_valid), 80'd0);
        checkOutput("flush2_in_ready", 80'(in_ready), 80'd1);

        // Flush with one entry while a new op is accepted in the same cycle.
        applyStimulus(32'h00430825, 32'd5, 32'd6);
        checkOutput("one_in_ready", 80'(in_ready), 80'd1);
        instr    = 32'h00430826;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("flush1_out_valid", 80'(out_valid), 80'd0);
        rdy_mode = 2;
        repeat (5) @(negedge clk);
        checkOutput("flush_quiet", 80'(out_valid), 80'd0);

        // Unrecognised opcode.
        rdy_mode = 1;
        @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
        instr    = 32'hFC000000;
        in_valid = 1'b1;
        checkOutput("trap_in_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("trap_pulse", 80'(illegal), 80'd1);
        checkOutput("trap_no_issue", 80'(out_valid), 80'd0);
        @(negedge clk);
        checkOutput("trap_pulse_end", 80'(illegal), 80'd0);
`else
        applyStimulus(32'hFC000000, 32'h55, 32'h66);
        checkOutput("nop_illegal_low", 80'(illegal), 80'd0);
`endif
        drain();

        // Randomised traffic with random gaps and random EX back-pressure.
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(genInstr(), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
